// File: rtl/btn_pkg.sv
// Shared types and default timing for the multi-channel button debouncer.
package btn_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      PEND_HI   = 2'd1,
      STABLE_HI = 2'd2,
      PEND_LO   = 2'd3
   } btn_state_t;

   localparam int DEF_N_CH            = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 100000;
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_LONG_CYCLES     = 50000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, 4-state debounce FSM and, with
// BTN_LONGPRESS_EN defined, a saturating hold counter for long-press strobes.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES
`ifdef BTN_LONGPRESS_EN
   ,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic debounced,
   output logic press_pulse,
`ifdef BTN_LONGPRESS_EN
   output logic long_press,
`endif
   output logic release_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   btn_state_t             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
   logic                   deb_q, deb_d;
   logic                   press_q, press_d;
   logic                   rel_q, rel_d;
   logic                   s;

   assign s       = sync_q[SYNC_STAGES-1];
   assign cnt_inc = cnt_q + CW'(1);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], btn};
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
         STABLE_LO: if (s) begin
            state_d = PEND_HI;
            cnt_d   = CW'(1);
         end
         PEND_HI: if (!s) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            deb_d   = 1'b1;
            press_d = 1'b1;
         end else begin
            cnt_d   = cnt_inc;
         end
         STABLE_HI: if (!s) begin
            state_d = PEND_LO;
            cnt_d   = CW'(1);
         end
         PEND_LO: if (s) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
         end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            deb_d   = 1'b0;
            rel_d   = 1'b1;
         end else begin
            cnt_d   = cnt_inc;
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef BTN_LONGPRESS_EN
   localparam int HW = $clog2(LONG_CYCLES + 1);

   logic [HW-1:0] hold_q, hold_d, hold_inc;
   logic          long_q, long_d;

   assign hold_inc = hold_q + HW'(1);

   // Only a genuine press restarts the hold; a rejected release glitch keeps counting.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (state_q == PEND_HI && state_d == STABLE_HI) begin
         hold_d = '0;
      end else if ((state_q == STABLE_HI || state_q == PEND_LO) &&
                   hold_q != HW'(LONG_CYCLES)) begin
         hold_d = hold_inc;
         long_d = (hold_inc == HW'(LONG_CYCLES));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_press = long_q;
`endif

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         deb_q   <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         deb_q   <= deb_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign debounced     = deb_q;
   assign press_pulse   = press_q;
   assign release_pulse = rel_q;

endmodule

// File: rtl/multi_btn_debouncer.sv
// N_CH independent button debouncers; long_press port exists only with
// BTN_LONGPRESS_EN defined.
module multi_btn_debouncer
   import btn_pkg::*;
#(
   parameter int N_CH            = DEF_N_CH,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES
`ifdef BTN_LONGPRESS_EN
   ,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn,
   output logic [N_CH-1:0] debounced_btn,
   output logic [N_CH-1:0] press_pulse,
`ifdef BTN_LONGPRESS_EN
   output logic [N_CH-1:0] long_press,
`endif
   output logic [N_CH-1:0] release_pulse
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
`ifdef BTN_LONGPRESS_EN
         ,
         .LONG_CYCLES     (LONG_CYCLES)
`endif
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .btn           (btn[g]),
         .debounced     (debounced_btn[g]),
         .press_pulse   (press_pulse[g]),
`ifdef BTN_LONGPRESS_EN
         .long_press    (long_press[g]),
`endif
         .release_pulse (release_pulse[g])
      );
   end

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Scoreboard bench for multi_btn_debouncer (N_CH=2, DEBOUNCE_CYCLES=8, SYNC_STAGES=2, LONG_CYCLES=20).
module tb_multi_btn_debouncer;

   localparam int N_CH = 2;
   localparam int DEB  = 8;
   localparam int SYNC = 2;
   localparam int LAT  = SYNC + DEB;
   localparam int LONG = 20;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic [N_CH-1:0] btn   = '0;
   logic [N_CH-1:0] debounced_btn, press_pulse, release_pulse;
   logic [N_CH-1:0] lng_obs;
`ifdef BTN_LONGPRESS_EN
   logic [N_CH-1:0] long_press;
   assign lng_obs = long_press;
`else
   assign lng_obs = '0;
`endif

   typedef struct {
      int              cyc;
      logic [N_CH-1:0] press;
      logic [N_CH-1:0] rel;
      logic [N_CH-1:0] lng;
   } ev_t;

   ev_t exp_q[$];
   int  cyc      = 0;
   int  n_checks = 0;
   int  n_fail   = 0;

   multi_btn_debouncer #(
      .N_CH            (N_CH),
      .DEBOUNCE_CYCLES (DEB),
      .SYNC_STAGES     (SYNC)
`ifdef BTN_LONGPRESS_EN
      ,
      .LONG_CYCLES     (LONG)
`endif
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn           (btn),
      .debounced_btn (debounced_btn),
      .press_pulse   (press_pulse),
`ifdef BTN_LONGPRESS_EN
      .long_press    (long_press),
`endif
      .release_pulse (release_pulse)
   );

   always #5 clk = ~clk;

   // Monitor: every strobe must match the next expected event, cycle-exact.
   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      if ((press_pulse | release_pulse | lng_obs) != '0) begin
         n_checks++;
         if ((press_pulse & release_pulse) != '0) begin
            n_fail++;
            $display("FAIL overlap cyc=%0d press=%b release=%b", cyc, press_pulse, release_pulse);
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b long=%b (none expected)",
                     cyc, press_pulse, release_pulse, lng_obs);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc !== cyc || e.press !== press_pulse || e.rel !== release_pulse ||
                e.lng !== lng_obs) begin
               n_fail++;
               $display("FAIL pulse got cyc=%0d p=%b r=%b l=%b expected cyc=%0d p=%b r=%b l=%b",
                        cyc, press_pulse, release_pulse, lng_obs, e.cyc, e.press, e.rel, e.lng);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic wait_drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      int c;
      rst_n = 1'b0;
      btn   = 2'b11;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({debounced_btn, press_pulse, release_pulse, lng_obs} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got deb=%b p=%b r=%b l=%b expected all 0",
                  debounced_btn, press_pulse, release_pulse, lng_obs);
      end
      rst_n = 1'b1;
      c = cyc;
      exp_q.push_back('{c + LAT, 2'b11, 2'b00, 2'b00});
      repeat (LAT - 1) @(negedge clk);
      n_checks++;
      if (debounced_btn !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_early_level got %b expected 00", debounced_btn);
      end
      @(negedge clk);
      n_checks++;
      if (debounced_btn !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_release_level got %b expected 11", debounced_btn);
      end
      wait_drain();
      btn = 2'b00;
      exp_q.push_back('{cyc + LAT, 2'b00, 2'b11, 2'b00});
      wait_drain();
      n_checks++;
      if (exp_q.size() != 0 || debounced_btn !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_release_both pending=%0d deb=%b expected 0 and 00",
                  exp_q.size(), debounced_btn);
      end
      exp_q.delete();
   endtask

   task automatic test_clean_press();
      int c;
      btn[0] = 1'b1;
      c = cyc;
      exp_q.push_back('{c + LAT, 2'b01, 2'b00, 2'b00});
      repeat (LAT - 1) @(negedge clk);
      n_checks++;
      if (debounced_btn !== 2'b00) begin
         n_fail++;
         $display("FAIL clean_early got %b expected 00", debounced_btn);
      end
      @(negedge clk);
      n_checks++;
      if (debounced_btn !== 2'b01) begin
         n_fail++;
         $display("FAIL clean_level got %b expected 01", debounced_btn);
      end
      wait_drain();
      btn[0] = 1'b0;
      exp_q.push_back('{cyc + LAT, 2'b00, 2'b01, 2'b00});
      wait_drain();
      n_checks++;
      if (exp_q.size() != 0 || debounced_btn !== 2'b00) begin
         n_fail++;
         $display("FAIL clean_release pending=%0d deb=%b expected 0 and 00",
                  exp_q.size(), debounced_btn);
      end
      exp_q.delete();
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 10; i++) begin
         btn[0] = ~btn[0];
         repeat (3) @(negedge clk);
      end
      btn[0] = 1'b1;
      exp_q.push_back('{cyc + LAT, 2'b01, 2'b00, 2'b00});
      wait_drain();
      n_checks++;
      if (exp_q.size() != 0 || debounced_btn !== 2'b01) begin
         n_fail++;
         $display("FAIL bounce_press pending=%0d deb=%b expected 0 and 01",
                  exp_q.size(), debounced_btn);
      end
      exp_q.delete();
      btn[0] = 1'b0;
      exp_q.push_back('{cyc + LAT, 2'b00, 2'b01, 2'b00});
      wait_drain();
      exp_q.delete();
   endtask

   task automatic test_release_glitch();
      int  p;
      logic bad;
      btn[0] = 1'b1;
      p = cyc + LAT;
      exp_q.push_back('{p, 2'b01, 2'b00, 2'b00});
`ifdef BTN_LONGPRESS_EN
      exp_q.push_back('{p + LONG, 2'b00, 2'b00, 2'b01});
`endif
      repeat (LAT) @(negedge clk);
      btn[0] = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == DEB - 1) btn[0] = 1'b1;
         @(negedge clk);
         if (debounced_btn[0] !== 1'b1) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL glitch_level got debounced_btn[0] low expected held 1");
      end
      wait_drain();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL glitch_events pending=%0d expected 0", exp_q.size());
      end
      exp_q.delete();
      btn[0] = 1'b0;
      exp_q.push_back('{cyc + LAT, 2'b00, 2'b01, 2'b00});
      wait_drain();
      exp_q.delete();
   endtask

   task automatic test_mid_pend_reset();
      btn[0] = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({debounced_btn, press_pulse, release_pulse, lng_obs} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs got deb=%b p=%b r=%b expected all 0",
                  debounced_btn, press_pulse, release_pulse);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back('{cyc + LAT, 2'b01, 2'b00, 2'b00});
      repeat (LAT - 1) @(negedge clk);
      n_checks++;
      if (debounced_btn !== 2'b00) begin
         n_fail++;
         $display("FAIL midreset_early got %b expected 00", debounced_btn);
      end
      wait_drain();
      n_checks++;
      if (exp_q.size() != 0 || debounced_btn !== 2'b01) begin
         n_fail++;
         $display("FAIL midreset_restart pending=%0d deb=%b expected 0 and 01",
                  exp_q.size(), debounced_btn);
      end
      exp_q.delete();
      btn[0] = 1'b0;
      exp_q.push_back('{cyc + LAT, 2'b00, 2'b01, 2'b00});
      wait_drain();
      exp_q.delete();
   endtask

   task automatic test_long_press();
      int c;
      btn[1] = 1'b1;
      c = cyc;
      exp_q.push_back('{c + LAT, 2'b10, 2'b00, 2'b00});
`ifdef BTN_LONGPRESS_EN
      exp_q.push_back('{c + LAT + LONG, 2'b00, 2'b00, 2'b10});
`endif
      exp_q.push_back('{c + 40 + LAT, 2'b00, 2'b10, 2'b00});
      repeat (40) @(negedge clk);
      n_checks++;
      if (debounced_btn !== 2'b10) begin
         n_fail++;
         $display("FAIL long_level got %b expected 10", debounced_btn);
      end
      btn[1] = 1'b0;
      wait_drain();
      n_checks++;
      if (exp_q.size() != 0 || debounced_btn !== 2'b00) begin
         n_fail++;
         $display("FAIL long_events pending=%0d deb=%b expected 0 and 00",
                  exp_q.size(), debounced_btn);
      end
      exp_q.delete();
   endtask

   task automatic test_simultaneous();
      btn = 2'b11;
      exp_q.push_back('{cyc + LAT, 2'b11, 2'b00, 2'b00});
      repeat (LAT + 2) @(negedge clk);
      btn = 2'b00;
      exp_q.push_back('{cyc + LAT, 2'b00, 2'b11, 2'b00});
      wait_drain();
      n_checks++;
      if (exp_q.size() != 0 || debounced_btn !== 2'b00) begin
         n_fail++;
         $display("FAIL simultaneous pending=%0d deb=%b expected 0 and 00",
                  exp_q.size(), debounced_btn);
      end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_glitch();
      test_mid_pend_reset();
      test_long_press();
      test_simultaneous();
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_btn_debouncer.md
MULTI_BTN_DEBOUNCER -- requirements
Module: multi_btn_debouncer

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000: consecutive stable clock cycles required before a level change is accepted, minimum 2.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flop depth per channel, minimum 2.
REQ-004 Parameter LONG_CYCLES, default 50000000: stable-high cycles required for a long-press event; used only with BTN_LONGPRESS_EN.
REQ-005 Port clk, input, 1 bit: the single clock; every flop is rising-edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port btn, input, N_CH bits: raw asynchronous button levels, active-high.
REQ-008 Port debounced_btn, output, N_CH bits: filtered level per channel.
REQ-009 Port press_pulse, output, N_CH bits: one-cycle strobe on an accepted 0->1 change.
REQ-010 Port release_pulse, output, N_CH bits: one-cycle strobe on an accepted 1->0 change.
REQ-011 Port long_press, output, N_CH bits: one-cycle strobe per press held for LONG_CYCLES; present only with BTN_LONGPRESS_EN.

Function
REQ-012 Each channel SHALL pass btn[i] through SYNC_STAGES flops before any other logic uses it; the output of these flops is s[i].
REQ-013 Each channel SHALL run a 4-state FSM with states STABLE_LO, PEND_HI, STABLE_HI and PEND_LO.
REQ-014 The channel counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide.
REQ-015 In STABLE_LO, when s=1 the FSM SHALL go to PEND_HI with count=1.
REQ-016 In PEND_HI, while s=1 the count SHALL increment each cycle.
REQ-017 In PEND_HI, when the count reaches DEBOUNCE_CYCLES with s still 1, the FSM SHALL go to STABLE_HI; debounced_btn[i] and press_pulse[i] SHALL be 1 in the first cycle of STABLE_HI.
REQ-018 In PEND_HI, any cycle with s=0 SHALL return the FSM to STABLE_LO with the count cleared and no pulse.
REQ-019 STABLE_HI and PEND_LO SHALL behave symmetrically to REQ-015..018, with release_pulse[i] in place of press_pulse[i] and debounced_btn[i] falling to 0.
REQ-020 A single btn edge SHALL reach debounced_btn exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
REQ-021 press_pulse[i] and release_pulse[i] SHALL each be high for exactly one cycle per accepted change and SHALL never be high in the same cycle.
REQ-022 Channels SHALL be fully independent; simultaneous events on any subset of channels SHALL each produce their own correct pulses in the same cycle.
REQ-023 All outputs SHALL be driven directly from flops, with no combinational path from btn to any output.

Reset
REQ-024 While rst_n=0, all synchroniser flops, counters and outputs SHALL be 0, and every FSM SHALL be in STABLE_LO.
REQ-025 Reset asserted mid-PEND SHALL abort the pending change with no pulse.
REQ-026 After reset release, a btn held high SHALL produce debounced_btn=1 and one press_pulse after the REQ-020 latency.

Configuration
REQ-027 With macro BTN_LONGPRESS_EN defined, each channel SHALL add a hold counter of $clog2(LONG_CYCLES+1) bits that is cleared on entry to STABLE_HI and keeps counting while the FSM is in STABLE_HI or PEND_LO.
REQ-028 With BTN_LONGPRESS_EN defined, long_press[i] SHALL pulse once when the hold count reaches LONG_CYCLES; the counter SHALL then saturate, and there SHALL be no re-pulse until the next press.
REQ-029 With BTN_LONGPRESS_EN undefined, the long_press port, the hold counter and LONG_CYCLES SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-030 Package btn_pkg SHALL hold the FSM state enum (btn_state_t, 2 bits) and the default timing constants.
REQ-031 Sub-module btn_debounce_ch SHALL implement one channel (sync, FSM, counters), and the top SHALL instantiate it N_CH times via a generate loop.

Verification (N_CH=2, DEBOUNCE_CYCLES=8, SYNC_STAGES=2, LONG_CYCLES=20)
REQ-032 Reset: hold rst_n=0 with btn=2'b11 -> all outputs 0; release -> debounced_btn=2'b11 and a press_pulse on both channels 10 cycles later.
REQ-033 Clean press: btn[0] rises and is held -> debounced_btn[0] rises exactly 10 cycles after the edge, press_pulse[0] is high 1 cycle, and channel 1 is unchanged.
REQ-034 Bounce: btn[0] toggles every 3 cycles for 30 cycles and then stays at 1 -> no pulse during the toggling, and a single press_pulse 10 cycles after the final edge.
REQ-035 Release glitch: with the channel in STABLE_HI, btn low for 7 cycles then back high -> no release_pulse and debounced_btn stays 1.
REQ-036 Mid-pend reset: rst_n pulsed low 5 cycles after a btn edge -> no pulse, outputs 0, and the filter restarts after release.
REQ-037 Long press (BTN_LONGPRESS_EN): btn[1] held 40 cycles -> long_press[1] pulses once, exactly 20 cycles after press_pulse[1], with none in a build without the macro.
